// File: rtl/io_fabric_pkg.sv
// Shared types and constants for the CPU IO fabric: FSM states, the IO page
// that decodes to the slave ports, and the data returned on a bus error.
package io_fabric_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Upper six address bits that select the IO window.
    localparam logic [5:0] IO_PAGE = 6'h3f;

    // Error read data, sliced down to DATA_W by the user (DATA_W <= 64).
    localparam logic [63:0] ERR_DATA = 64'hFFFF_FFFF_FFFF_FFFF;

    // True when an address falls inside the IO window.
    function automatic logic is_io_page(input logic [15:0] addr);
        return (addr[15:10] == IO_PAGE);
    endfunction

endpackage

// File: rtl/io_fabric_timer.sv
// Access timer for the IO fabric: cleared when an access is issued, counts
// while the fabric waits for an acknowledge, flags expiry at TIMEOUT.
module io_fabric_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic nreset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count_r;

    // Wait-cycle counter; clear has priority over counting.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            count_r <= 8'd0;
        end else if (clear) begin
            count_r <= 8'd0;
        end else if (enable) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == 8'(TIMEOUT));

endmodule

// File: rtl/io_fabric.sv
// CPU IO fabric: routes CPU accesses either to main memory (never stalled)
// or to one of NUM_SLAVES IO slaves, stalling the CPU until the slave
// acknowledges or the access times out, and recording bus errors.
module io_fabric
    import io_fabric_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int SLAVE_BITS = 3,
    parameter int DATA_W     = 16,
    parameter int TIMEOUT    = 15
) (
    input  logic                         clk,
    input  logic                         nreset,
    input  logic                         cpu_en,
    input  logic                         cpu_wr,
    input  logic [15:0]                  cpu_addr,
    input  logic [DATA_W-1:0]            cpu_dout,
    output logic [DATA_W-1:0]            cpu_din,
    output logic                         cpu_wait,
    output logic                         mem_en,
    output logic                         mem_wr,
    input  logic [DATA_W-1:0]            mem_dout,
    output logic [NUM_SLAVES-1:0]        slv_en,
    output logic [NUM_SLAVES-1:0]        slv_wr,
    output logic [10-SLAVE_BITS-1:0]     slv_addr,
    output logic [DATA_W-1:0]            slv_wdata,
    input  logic [NUM_SLAVES*DATA_W-1:0] slv_rdata,
    input  logic [NUM_SLAVES-1:0]        slv_ack,
    input  logic                         err_clr,
    output logic                         bus_err,
    output logic [15:0]                  err_addr
);

    localparam logic [DATA_W-1:0] ERR_WORD = ERR_DATA[DATA_W-1:0];

    state_e                  state_r;
    logic [SLAVE_BITS-1:0]   sel_r;
    logic [15:0]             addr_r;
    logic                    wr_r;
    logic [DATA_W-1:0]       rdata_r;
    logic                    rd_sel_r;
    logic                    bus_err_r;
    logic [15:0]             err_addr_r;

    logic                    io_s;
    logic [SLAVE_BITS-1:0]   slv_idx_s;
    logic                    mapped_s;
    logic                    req_io_s;
    logic                    issue_s;
    logic                    unmapped_s;
    logic                    in_wait_s;
    logic                    expired_s;
    logic                    ack_s;
    logic [DATA_W-1:0]       ack_data_s;
    logic                    timeout_s;
    logic                    err_set_s;
    logic [15:0]             err_addr_nxt_s;
    logic [NUM_SLAVES-1:0]   slv_en_s;

    assign io_s      = is_io_page(cpu_addr);
    assign slv_idx_s = cpu_addr[9 -: SLAVE_BITS];
    assign mapped_s  = (32'(slv_idx_s) < NUM_SLAVES);
    assign in_wait_s = (state_r == ST_WAIT);

    // New IO requests are only accepted in IDLE; reset masks them so the
    // strobe and stall drop immediately when nreset falls.
    assign req_io_s   = nreset & cpu_en & io_s & (state_r == ST_IDLE);
    assign issue_s    = req_io_s & mapped_s;
    assign unmapped_s = req_io_s & ~mapped_s;

    // An acknowledge in the expiry cycle completes the access normally.
    assign timeout_s      = in_wait_s & ~ack_s & expired_s;
    assign err_set_s      = unmapped_s | timeout_s;
    assign err_addr_nxt_s = unmapped_s ? cpu_addr : addr_r;

    assign mem_en    = cpu_en & ~io_s;
    assign mem_wr    = mem_en & cpu_wr;
    assign cpu_wait  = issue_s | (in_wait_s & ~ack_s & ~expired_s);
    assign slv_en    = slv_en_s;
    assign slv_wr    = slv_en_s & {NUM_SLAVES{cpu_wr}};
    assign slv_addr  = cpu_addr[9-SLAVE_BITS:0];
    assign slv_wdata = cpu_dout;
    assign cpu_din   = rd_sel_r ? rdata_r : mem_dout;
    assign bus_err   = bus_err_r;
    assign err_addr  = err_addr_r;

    // One-hot strobe decode for the slave addressed by this request.
    always_comb begin
        slv_en_s = {NUM_SLAVES{1'b0}};
        for (int i = 0; i < NUM_SLAVES; i++) begin
            slv_en_s[i] = issue_s & (slv_idx_s == SLAVE_BITS'(i));
        end
    end

    // Select ack and read data of the slave captured at issue; others are ignored.
    always_comb begin
        ack_s      = 1'b0;
        ack_data_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_SLAVES; i++) begin
            ack_s      = ack_s | (slv_ack[i] & (sel_r == SLAVE_BITS'(i)));
            ack_data_s = (sel_r == SLAVE_BITS'(i)) ? slv_rdata[i*DATA_W +: DATA_W] : ack_data_s;
        end
    end

    io_fabric_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .nreset  (nreset),
        .clear   (issue_s),
        .enable  (in_wait_s),
        .expired (expired_s)
    );

    // Access FSM, returned read data and sticky error record.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_r    <= ST_IDLE;
            sel_r      <= {SLAVE_BITS{1'b0}};
            addr_r     <= 16'h0000;
            wr_r       <= 1'b0;
            rdata_r    <= {DATA_W{1'b0}};
            rd_sel_r   <= 1'b0;
            bus_err_r  <= 1'b0;
            err_addr_r <= 16'h0000;
        end else begin
            rd_sel_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (issue_s) begin
                        state_r <= ST_WAIT;
                        sel_r   <= slv_idx_s;
                        addr_r  <= cpu_addr;
                        wr_r    <= cpu_wr;
                    end else if (unmapped_s) begin
                        rdata_r  <= ERR_WORD;
                        rd_sel_r <= ~cpu_wr;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (ack_s) begin
                        state_r  <= ST_IDLE;
                        rdata_r  <= wr_r ? rdata_r : ack_data_s;
                        rd_sel_r <= ~wr_r;
                    end else if (expired_s) begin
                        state_r  <= ST_IDLE;
                        rdata_r  <= wr_r ? rdata_r : ERR_WORD;
                        rd_sel_r <= ~wr_r;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase

            // A new error beats err_clr; the address only reloads on a fresh error.
            if (err_set_s) begin
                bus_err_r <= 1'b1;
                if (!bus_err_r || err_clr) begin
                    err_addr_r <= err_addr_nxt_s;
                end else begin
                    err_addr_r <= err_addr_r;
                end
            end else if (err_clr) begin
                bus_err_r <= 1'b0;
            end else begin
                bus_err_r <= bus_err_r;
            end
        end
    end

endmodule
